bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_bus_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: word RAM plus a small MMIO block (cycle counter,
// TX FIFO, status and clear) behind a single-cycle strobe bus.
module bus_mem_responder #(
   parameter int unsigned MEM_WORDS  = 1024,
   parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_en_i,
   input  logic        wr_en_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        out_valid_o,
   output logic [31:0] out_data_o,
   input  logic        out_ready_i,
   output logic        bus_err_o
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [31:0] OFF_CYCLE  = 32'h0;
   localparam logic [31:0] OFF_TXDATA = 32'h4;
   localparam logic [31:0] OFF_STATUS = 32'h8;
   localparam logic [31:0] OFF_CLEAR  = 32'hC;

   // address decode
   logic          is_mmio;
   logic          misal;
   logic          ram_oor;
   logic          ram_hit;
   logic          mmio_bad;
   logic          access;
   logic          err_evt;
   logic          sel_cyc;
   logic          sel_tx;
   logic          sel_st;
   logic          sel_clr;
   logic [31:0]   word_addr;
   logic [31:0]   mmio_off;
   logic [AW-1:0] ram_idx;

   assign is_mmio   = addr_i[31];
   assign word_addr = {addr_i[31:2], 2'b00};
   assign mmio_off  = word_addr - MMIO_BASE;
   assign ram_idx   = addr_i[AW+1:2];
   assign ram_oor   = ~is_mmio & (|addr_i[30:AW+2]);
   assign ram_hit   = ~is_mmio & ~ram_oor;
   assign misal     = |addr_i[1:0];

   assign sel_cyc = is_mmio & (mmio_off == OFF_CYCLE);
   assign sel_tx  = is_mmio & (mmio_off == OFF_TXDATA);
   assign sel_st  = is_mmio & (mmio_off == OFF_STATUS);
   assign sel_clr = is_mmio & (mmio_off == OFF_CLEAR);

   assign mmio_bad = is_mmio & ~(sel_cyc | sel_tx | sel_st | sel_clr);
   assign access   = rd_en_i | wr_en_i;
   assign err_evt  = access & (misal | ram_oor | mmio_bad);

   // RAM: no reset on contents; a write during reset is dropped
   logic [31:0] ram_q [MEM_WORDS];
   logic        ram_we;

   assign ram_we = wr_en_i & ram_hit & rst_n;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_idx] <= data_i;
      end
   end

   // MMIO state
   logic [31:0]   cycle_q;
   logic [31:0]   fifo_q [FIFO_DEPTH];
   logic [31:0]   fifo_d [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;

   logic        full;
   logic        empty;
   logic        push_req;
   logic        push_ok;
   logic        pop;
   logic        ovf_evt;
   logic        clr;
   logic [31:0] status;
   logic [31:0] rdata;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full  = (cnt_q == CW'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);

   assign push_req = wr_en_i & sel_tx;
   assign pop      = ~empty & out_ready_i;
   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign push_ok  = push_req & (~full | pop);
   assign ovf_evt  = push_req & full & ~pop;
   assign clr      = wr_en_i & sel_clr;

   assign status = {22'b0, err_q, ovf_q, 6'(cnt_q), empty, full};

   always_comb begin
      fifo_d = fifo_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      err_d  = err_q;
      if (push_ok) begin
         fifo_d[wptr_q] = data_i;
         wptr_d         = ptr_inc(wptr_q);
      end
      if (pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
      if (push_ok && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push_ok) begin
         cnt_d = cnt_q - CW'(1);
      end
      if (clr) begin
         ovf_d = 1'b0;
         err_d = 1'b0;
      end
      // new events override a coincident clear
      if (ovf_evt) begin
         ovf_d = 1'b1;
      end
      if (err_evt) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q <= '0;
         fifo_q  <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         fifo_q  <= fifo_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   // read mux
   always_comb begin
      rdata = '0;
      unique case (1'b1)
         ram_hit: rdata = ram_q[ram_idx];
         sel_cyc: rdata = cycle_q;
         sel_st:  rdata = status;
         default: rdata = '0;
      endcase
   end

   assign data_o      = rd_en_i ? rdata : '0;
   assign out_valid_o = ~empty;
   assign out_data_o  = empty ? '0 : fifo_q[rptr_q];
   assign bus_err_o   = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: vector table for decode/RAM,
// scoreboard queue for the TX FIFO, hand sequences for corner cases.
module tb_bus_mem_responder;

   localparam logic [31:0] A_CYC = 32'h8000_0000;
   localparam logic [31:0] A_TX  = 32'h8000_0004;
   localparam logic [31:0] A_ST  = 32'h8000_0008;
   localparam logic [31:0] A_CLR = 32'h8000_000C;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en_i = 1'b0;
   logic        wr_en_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic        out_ready_i = 1'b0;
   logic        bus_err_o;

   int n_pass = 0;
   int n_chk  = 0;

   logic [31:0] sb [$];

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_do;
      logic        exp_err;
   } vec_t;

   vec_t tbl [$];

   bus_mem_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_en_i     (rd_en_i),
      .wr_en_i     (wr_en_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .bus_err_o   (bus_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // apply one bus cycle at the falling edge; FIFO output that will be
   // consumed at the next rising edge is checked against the scoreboard
   task automatic drive(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic rdy);
      @(negedge clk);
      rd_en_i     = rd;
      wr_en_i     = wr;
      addr_i      = a;
      data_i      = d;
      out_ready_i = rdy;
      #1;
      if (out_valid_o && out_ready_i) begin
         if (sb.size() == 0) chk("sb_underflow", 32'(out_valid_o), 32'd0);
         else chk("fifo_out", out_data_o, sb.pop_front());
      end
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 1'b0, 32'h0, 32'h0, rdy);
   endtask

   logic [31:0] c1, c2;

   initial begin
      tbl.push_back('{"wr_ram0",   0, 1, 32'h0,    32'hCAFE_0000, 32'h0, 0});
      tbl.push_back('{"wr_ram10",  0, 1, 32'h10,   32'hDEAD_BEEF, 32'h0, 0});
      tbl.push_back('{"rd_ram10",  1, 0, 32'h10,   32'h0, 32'hDEAD_BEEF, 0});
      tbl.push_back('{"rd_off",    0, 0, 32'h10,   32'h0, 32'h0, 0});
      tbl.push_back('{"rdwr_old",  1, 1, 32'h10,   32'h1234_5678, 32'hDEAD_BEEF, 0});
      tbl.push_back('{"rd_new",    1, 0, 32'h10,   32'h0, 32'h1234_5678, 0});
      tbl.push_back('{"wr_top",    0, 1, 32'hFFC,  32'hA5A5_A5A5, 32'h0, 0});
      tbl.push_back('{"rd_top",    1, 0, 32'hFFC,  32'h0, 32'hA5A5_A5A5, 0});
      tbl.push_back('{"rd_oor",    1, 0, 32'h1002, 32'h0, 32'h0, 1});
      tbl.push_back('{"wr_oor",    0, 1, 32'h1000, 32'h1111_1111, 32'h0, 1});
      tbl.push_back('{"rd_noalias",1, 0, 32'h0,    32'h0, 32'hCAFE_0000, 0});
      tbl.push_back('{"rd_misal",  1, 0, 32'h13,   32'h0, 32'h1234_5678, 1});
      tbl.push_back('{"rd_badmmio",1, 0, 32'h8000_0010, 32'h0, 32'h0, 1});
      tbl.push_back('{"wr_cycle",  0, 1, A_CYC,    32'hFFFF, 32'h0, 0});
      tbl.push_back('{"rd_txdata", 1, 0, A_TX,     32'h0, 32'h0, 0});
      tbl.push_back('{"rd_clear",  1, 0, A_CLR,    32'h0, 32'h0, 0});
      tbl.push_back('{"rd_status", 1, 0, A_ST,     32'h0, 32'h2, 0});
      tbl.push_back('{"rd_bit30",  1, 0, 32'h4000_0000, 32'h0, 32'h0, 1});
      tbl.push_back('{"wr_badmmio",0, 1, 32'h8000_0020, 32'h5, 32'h0, 1});

      // reset state
      repeat (2) @(negedge clk);
      rd_en_i = 1'b1;
      addr_i  = A_CYC;
      #1;
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_odata", out_data_o, 32'h0);
      chk("rst_err", 32'(bus_err_o), 32'd0);
      chk("rst_cycle", data_o, 32'h0);
      rd_en_i = 1'b0;
      rst_n   = 1'b1;

      // first increment on the first edge after release
      drive(1'b1, 1'b0, A_CYC, 32'h0, 1'b0);
      chk("cycle_first", data_o, 32'd1);
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
      chk("rst_status", data_o, 32'h2);

      // vector table, each followed by a CLEAR write
      foreach (tbl[i]) begin
         drive(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0);
         chk({tbl[i].name, "_do"}, data_o, tbl[i].exp_do);
         drive(1'b0, 1'b1, A_CLR, 32'h0, 1'b0);
         chk({tbl[i].name, "_err"}, 32'(bus_err_o), 32'(tbl[i].exp_err));
      end
      idle(1'b0);
      chk("tbl_cleared", 32'(bus_err_o), 32'd0);

      // error flag visible in STATUS, clear, and clear vs. new error
      drive(1'b1, 1'b0, 32'h1002, 32'h0, 1'b0);
      chk("oor_do", data_o, 32'h0);
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
      chk("oor_err", 32'(bus_err_o), 32'd1);
      chk("oor_status", data_o, 32'h202);
      drive(1'b0, 1'b1, A_CLR | 32'h1, 32'h0, 1'b0);
      idle(1'b0);
      chk("clr_vs_err", 32'(bus_err_o), 32'd1);
      drive(1'b0, 1'b1, A_CLR, 32'h0, 1'b0);
      idle(1'b0);
      chk("clr_ok", 32'(bus_err_o), 32'd0);

      // three pushes, no drain, then drain
      for (int i = 1; i <= 3; i++) begin
         drive(1'b0, 1'b1, A_TX, 32'(i), 1'b0);
         sb.push_back(32'(i));
         if (i == 1) chk("no_bypass", 32'(out_valid_o), 32'd0);
         if (i == 2) chk("valid_next", 32'(out_valid_o), 32'd1);
      end
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
      chk("status_cnt3", data_o, 32'h0C);
      for (int i = 0; i < 3; i++) idle(1'b1);
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b1);
      chk("status_empty", data_o, 32'h2);
      chk("sb_drained3", 32'(sb.size()), 32'd0);

      // overflow: fifth push dropped
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, A_TX, 32'h10 + 32'(i), 1'b0);
         if (i < 4) sb.push_back(32'h10 + 32'(i));
      end
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
      chk("status_ovf", data_o, 32'h111);
      drive(1'b0, 1'b1, A_CLR, 32'h0, 1'b0);
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
      chk("status_clr", data_o, 32'h011);

      // push into full FIFO with simultaneous pop
      sb.push_back(32'h99);
      drive(1'b0, 1'b1, A_TX, 32'h99, 1'b1);
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
      chk("status_fullpop", data_o, 32'h011);
      for (int i = 0; i < 4; i++) idle(1'b1);
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b1);
      chk("status_empty2", data_o, 32'h2);
      chk("sb_drained4", 32'(sb.size()), 32'd0);

      // CYCLE distance
      drive(1'b1, 1'b0, A_CYC, 32'h0, 1'b0);
      c1 = data_o;
      for (int i = 0; i < 7; i++) idle(1'b0);
      drive(1'b1, 1'b0, A_CYC, 32'h0, 1'b0);
      c2 = data_o;
      chk("cycle_diff", c2 - c1, 32'd8);

      // mid-operation reset with a concurrent RAM write
      drive(1'b0, 1'b1, 32'h20, 32'h55, 1'b0);
      drive(1'b0, 1'b1, A_TX, 32'h77, 1'b0);
      idle(1'b0);
      chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
      drive(1'b0, 1'b1, 32'h20, 32'h66, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", 32'(out_valid_o), 32'd0);
      chk("rst_async_odata", out_data_o, 32'h0);
      sb.delete();
      @(negedge clk);
      wr_en_i = 1'b0;
      rd_en_i = 1'b1;
      addr_i  = A_CYC;
      #1;
      chk("rst_mid_cycle", data_o, 32'h0);
      rd_en_i = 1'b0;
      rst_n   = 1'b1;
      drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      chk("rst_wr_lost", data_o, 32'h55);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      chk("ram_kept", data_o, 32'h1234_5678);
      drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
      chk("post_rst_status", data_o, 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
